// File: rtl/sha256_arbiter_if.sv
// Requester-side bus of the SHA-256 core arbiter: level requests with their blocks in,
// grant/done pulses and the shared digest out.
interface sha256_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*512-1:0] req_block;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     done;
  logic [255:0]           hash_out;
  logic                   err;
  logic                   busy;
  logic [IDX_W-1:0]       owner;

  modport slave (
    input  req, req_block,
    output gnt, done, hash_out, err, busy, owner
  );

  modport master (
    output req, req_block,
    input  gnt, done, hash_out, err, busy, owner
  );
endinterface

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256_core among NUM_REQ requesters, with a
// watchdog that aborts a core transaction that never completes.
module sha256_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha256_arbiter_if.slave      bus,
  output logic                 core_start,
  output logic [511:0]         core_block,
  input  logic [255:0]         core_hash,
  input  logic                 core_hash_valid,
  input  logic                 core_ready
);
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [255:0]       hash_q, hash_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               start_q, start_d;
  logic [511:0]       blk_q, blk_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [WDOG_W-1:0]  wdog_inc;

  function automatic int wrap_idx(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Scan downward so the lowest offset from rr_q wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[wrap_idx(int'(rr_q) + k)]) begin
        win_idx   = IDX_W'(wrap_idx(int'(rr_q) + k));
        win_found = 1'b1;
      end
    end
  end

  assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + WDOG_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    hash_d  = hash_q;
    err_d   = err_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    start_d = start_q;
    blk_d   = blk_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found && core_ready) begin
          blk_d   = bus.req_block[int'(win_idx)*512 +: 512];
          owner_d = win_idx;
          gnt_d   = ONE_HOT0 << win_idx;
          rr_d    = IDX_W'(wrap_idx(int'(win_idx) + 1));
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!core_ready) begin
          start_d = 1'b0;
          wdog_d  = '0;
          state_d = S_WAIT;
        end else if (wdog_q >= WDOG_LIMIT) begin
          // Core never accepted the start: abort the same way as a stalled WAIT.
          start_d = 1'b0;
          err_d   = 1'b1;
          done_d  = ONE_HOT0 << owner_q;
          state_d = S_FINISH;
        end else begin
          wdog_d  = wdog_inc;
        end
      end
      S_WAIT: begin
        if (core_ready && core_hash_valid) begin
          hash_d  = core_hash;
          err_d   = 1'b0;
          done_d  = ONE_HOT0 << owner_q;
          state_d = S_FINISH;
        end else if (wdog_q >= WDOG_LIMIT) begin
          err_d   = 1'b1;
          done_d  = ONE_HOT0 << owner_q;
          state_d = S_FINISH;
        end else begin
          wdog_d  = wdog_inc;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      hash_q  <= '0;
      err_q   <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      start_q <= 1'b0;
      blk_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      start_q <= start_d;
      blk_q   <= blk_d;
      wdog_q  <= wdog_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.hash_out = hash_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.owner    = owner_q;
  assign core_start   = start_q;
  assign core_block   = blk_q;
endmodule
